// File: rtl/ldm_stm_reg_addr_generator_pkg.sv
// Shared widths and FSM state type for the LDM/STM register address sequencer.
package ldm_stm_pkg;
    localparam int REG_LIST_W = 16;
    localparam int REG_ADDR_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ldm_state_t;
endpackage

// File: rtl/ldm_stm_reg_addr_generator_lowest_set_bit_encoder.sv
// Combinational lowest-index priority encoder with valid flag and one-hot mask
// of the selected bit, used to peel registers off a list one at a time.
module lowest_set_bit_encoder
    import ldm_stm_pkg::*;
(
    input  logic [REG_LIST_W-1:0] list,
    output logic [REG_ADDR_W-1:0] idx,
    output logic                  valid,
    output logic [REG_LIST_W-1:0] onehot
);
    // Scan from the top so the lowest set bit wins the last assignment.
    always_comb begin
        idx = '0;
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            if (list[i]) idx = REG_ADDR_W'(i);
        end
    end

    assign valid  = |list;
    assign onehot = list & (~list + REG_LIST_W'(1));
endmodule

// File: rtl/ldm_stm_reg_addr_generator.sv
// LDM/STM sequencer: emits the set register numbers of a 16-bit list in
// ascending order, one per clock, qualified by ldm_stm_en_out.
module ldm_stm_reg_addr_generator
    import ldm_stm_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  ldm_stm_start_in,
    input  logic [REG_LIST_W-1:0] data_in,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic                  ldm_stm_en_out
);
    ldm_state_t            state;
    logic [REG_LIST_W-1:0] pending;

    logic [REG_ADDR_W-1:0] new_idx, pend_idx;
    logic                  new_vld, pend_vld;
    logic [REG_LIST_W-1:0] new_oh, pend_oh;

    lowest_set_bit_encoder u_enc_new (
        .list   (data_in),
        .idx    (new_idx),
        .valid  (new_vld),
        .onehot (new_oh)
    );

    lowest_set_bit_encoder u_enc_pend (
        .list   (pending),
        .idx    (pend_idx),
        .valid  (pend_vld),
        .onehot (pend_oh)
    );

    // Start has priority in every state, so a start while BUSY restarts with no gap.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state          <= IDLE;
            pending        <= '0;
            reg_addr_out   <= '0;
            ldm_stm_en_out <= 1'b0;
        end else if (ldm_stm_start_in) begin
            if (new_vld) begin
                state          <= BUSY;
                pending        <= data_in & ~new_oh;
                reg_addr_out   <= new_idx;
                ldm_stm_en_out <= 1'b1;
            end else begin
                state          <= IDLE;
                pending        <= '0;
                reg_addr_out   <= '0;
                ldm_stm_en_out <= 1'b0;
            end
        end else begin
            case (state)
                BUSY: begin
                    if (pend_vld) begin
                        pending        <= pending & ~pend_oh;
                        reg_addr_out   <= pend_idx;
                        ldm_stm_en_out <= 1'b1;
                    end else begin
                        state          <= IDLE;
                        reg_addr_out   <= '0;
                        ldm_stm_en_out <= 1'b0;
                    end
                end
                default: begin
                    reg_addr_out   <= '0;
                    ldm_stm_en_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ldm_stm_reg_addr_generator.sv
// Scoreboard bench for the LDM/STM register address sequencer.
module tb_ldm_stm_reg_addr_generator;
    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        ldm_stm_start_in;
    logic [15:0] data_in;
    logic [3:0]  reg_addr_out;
    logic        ldm_stm_en_out;

    int checks   = 0;
    int failures = 0;

    // Each entry is {en, addr} expected on one cycle.
    logic [4:0] exp_q[$];
    logic [4:0] e;

    ldm_stm_reg_addr_generator dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .ldm_stm_start_in (ldm_stm_start_in),
        .data_in          (data_in),
        .reg_addr_out     (reg_addr_out),
        .ldm_stm_en_out   (ldm_stm_en_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: one entry per set bit, ascending, then idle cycles.
    function automatic void push_list(input logic [15:0] list, input int idle_cycles);
        for (int i = 0; i < 16; i++)
            if (list[i]) exp_q.push_back({1'b1, 4'(i)});
        for (int i = 0; i < idle_cycles; i++)
            exp_q.push_back(5'b0_0000);
    endfunction

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Drives a one-cycle start; returns #1 after the sampling edge.
    task automatic start_pulse(input logic [15:0] list);
        ldm_stm_start_in = 1'b1;
        data_in          = list;
        next_cycle();
        ldm_stm_start_in = 1'b0;
        data_in          = 16'h0;
    endtask

    task automatic test_reset();
        reset_in         = 1'b1;
        ldm_stm_start_in = 1'b0;
        data_in          = 16'h0;
        #50;
        checks++;
        if ({ldm_stm_en_out, reg_addr_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold actual=%b required=00000", {ldm_stm_en_out, reg_addr_out});
        end
        #55;
        reset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if ({ldm_stm_en_out, reg_addr_out} !== 5'b0) begin
                failures++;
                $display("FAIL reset_release actual=%b required=00000", {ldm_stm_en_out, reg_addr_out});
            end
        end
    endtask

    task automatic test_basic_list();
        start_pulse(16'h0721);
        push_list(16'h0721, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({ldm_stm_en_out, reg_addr_out} !== e) begin
                failures++;
                $display("FAIL basic_0721 actual=%b required=%b", {ldm_stm_en_out, reg_addr_out}, e);
            end
            if (exp_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_empty_list();
        start_pulse(16'h0000);
        push_list(16'h0000, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({ldm_stm_en_out, reg_addr_out} !== e) begin
                failures++;
                $display("FAIL empty_list actual=%b required=%b", {ldm_stm_en_out, reg_addr_out}, e);
            end
            if (exp_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_full_and_top();
        logic [15:0] lists[2] = '{16'hFFFF, 16'h8000};
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            start_pulse(lists[k]);
            push_list(lists[k], 2);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({ldm_stm_en_out, reg_addr_out} !== e) begin
                    failures++;
                    $display("FAIL full_top list=%h actual=%b required=%b",
                             lists[k], {ldm_stm_en_out, reg_addr_out}, e);
                end
                if (exp_q.size() > 0) next_cycle();
            end
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        start_pulse(16'h00F0);
        exp_q.push_back({1'b1, 4'd4});
        exp_q.push_back({1'b1, 4'd5});
        push_list(16'h0003, 4);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if ({ldm_stm_en_out, reg_addr_out} !== e) begin
                failures++;
                $display("FAIL restart_busy step=%0d actual=%b required=%b",
                         n, {ldm_stm_en_out, reg_addr_out}, e);
            end
            // Restart lands in the cycle that shows address 5.
            if (n == 1) begin
                ldm_stm_start_in = 1'b1;
                data_in          = 16'h0003;
                next_cycle();
                ldm_stm_start_in = 1'b0;
                data_in          = 16'h0;
            end else if (exp_q.size() > 0) begin
                next_cycle();
            end
        end
    endtask

    task automatic test_async_reset();
        next_cycle();
        start_pulse(16'h0F00);
        checks++;
        if ({ldm_stm_en_out, reg_addr_out} !== {1'b1, 4'd8}) begin
            failures++;
            $display("FAIL areset_pre8 actual=%b required=11000", {ldm_stm_en_out, reg_addr_out});
        end
        next_cycle();
        checks++;
        if ({ldm_stm_en_out, reg_addr_out} !== {1'b1, 4'd9}) begin
            failures++;
            $display("FAIL areset_pre9 actual=%b required=11001", {ldm_stm_en_out, reg_addr_out});
        end
        #2 reset_in = 1'b1;
        #1;
        checks++;
        if ({ldm_stm_en_out, reg_addr_out} !== 5'b0) begin
            failures++;
            $display("FAIL areset_immediate actual=%b required=00000", {ldm_stm_en_out, reg_addr_out});
        end
        next_cycle();
        #2 reset_in = 1'b0;
        push_list(16'h0000, 5);
        while (exp_q.size() > 0) begin
            next_cycle();
            e = exp_q.pop_front();
            checks++;
            if ({ldm_stm_en_out, reg_addr_out} !== e) begin
                failures++;
                $display("FAIL areset_after actual=%b required=%b", {ldm_stm_en_out, reg_addr_out}, e);
            end
        end
    endtask

    task automatic test_held_start();
        next_cycle();
        ldm_stm_start_in = 1'b1;
        data_in          = 16'h0001;
        next_cycle();
        exp_q.push_back({1'b1, 4'd0});
        push_list(16'h0006, 3);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front();
            checks++;
            if ({ldm_stm_en_out, reg_addr_out} !== e) begin
                failures++;
                $display("FAIL held_start step=%0d actual=%b required=%b",
                         n, {ldm_stm_en_out, reg_addr_out}, e);
            end
            if (n == 0) begin
                data_in = 16'h0006;
                next_cycle();
                ldm_stm_start_in = 1'b0;
                data_in          = 16'h0;
            end else if (exp_q.size() > 0) begin
                next_cycle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_list();
        test_empty_list();
        test_full_and_top();
        test_back_to_back();
        test_async_reset();
        test_held_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
